ttt_game_ctrl: RTL and testbench
================================

// Module: ttt_game_ctrl
// PURPOSE
//  Turn sequencer and board owner for the 3x3 tic-tac-toe VGA game.
//  Edge-detects the place/new-game buttons, checks each move against the 9-cell board,
//  alternates players X/O, enforces an optional per-turn time limit, and detects win/draw.
//  Board and cursor outputs feed the cell-select decode and the VGA cell renderer.
// PARAMETERS
//  TURN_LIMIT    10  sec_tick count per turn; 0 disables the turn timer
//  START_PLAYER  0   player moving first after reset/new game (0=X, 1=O)
// PORTS
//  clk         in   1   system clock; the block's only clock
//  rst         in   1   synchronous, active-high reset
//  cursor      in   4   selected cell 0..8 (row-major); 9..15 invalid
//  place       in   1   place button level (synchronized/debounced upstream)
//  new_game    in   1   new-game button level (synchronized/debounced upstream)
//  sec_tick    in   1   one-cycle timer strobe
//  board       out  18  cell i at [2i+1:2i]: 00 empty, 01 X, 10 O
//  turn        out  1   player to move (0=X, 1=O)
//  state       out  2   00 PLAY, 01 CHECK, 10 WIN, 11 DRAW
//  winner      out  2   00 none, 01 X, 10 O
//  win_line    out  9   mask of the winning line's cells
//  sel_onehot  out  9   one-hot of cursor when cursor<=8; else 0 (registered, 1-cycle lag)
//  move_ok     out  1   1-cycle pulse: move accepted
//  move_err    out  1   1-cycle pulse: move rejected
//  timeout     out  1   1-cycle pulse: turn forfeited by timer
//  time_left   out  TW  remaining ticks; TW = max(1,$clog2(TURN_LIMIT+1))
// BEHAVIOUR
//  Reset:
//   - board=0, turn=START_PLAYER, state=PLAY, winner=0, win_line=0, sel_onehot=0
//   - all pulses 0, time_left=TURN_LIMIT
//   - edge registers place_q/new_q reset to 1, so a button held through reset
//     produces no action.
//  Edges: pe = place & ~place_q; ne = new_game & ~new_q; evaluated every cycle.
//  PLAY, cycle t, pe=1:
//   - cursor<=8 and cell empty: at t+1 the cell holds the turn's symbol, move_ok=1,
//     state=CHECK.
//   - otherwise: at t+1 move_err=1; board, turn, and state are unchanged.
//  CHECK (exactly 1 cycle): evaluates 8 lines (3 rows, 3 cols, 2 diags) on the updated board.
//   - Line complete: state=WIN, winner=mover, win_line=that line's mask. If two lines
//     complete at once, the lowest index wins (rows, then cols, then diags).
//   - Else all 9 cells full: state=DRAW. Win has precedence over draw on the 9th move.
//   - Else: state=PLAY, turn toggles, time_left reloads to TURN_LIMIT.
//   - pe during CHECK is ignored (no pulse).
//  Timer (PLAY, TURN_LIMIT>0):
//   - sec_tick decrements time_left.
//   - sec_tick with time_left==1: timeout=1, turn toggles, time_left=TURN_LIMIT, board unchanged.
//   - pe and expiring sec_tick in the same cycle: the move is processed and the tick is dropped.
//   - time_left is frozen in CHECK/WIN/DRAW.
//   - TURN_LIMIT=0: time_left stays 0, timeout never fires.
//  WIN/DRAW: board, winner, and win_line hold; pe ignored.
//  ne in any state: next cycle board=0, turn=START_PLAYER, state=PLAY, winner=0, win_line=0,
//   time_left=TURN_LIMIT. ne has priority over a simultaneous pe, which is dropped (no pulse).
//  rst asserted mid-move or during CHECK aborts the move; the reset values apply next cycle.
// TESTING
//  T1: reset; cursor=4, place 0->1 -> next cycle board[9:8]=01, move_ok=1;
//      a cycle later state=PLAY, turn=1.
//  T2: after T1, cursor=4, place edge -> move_err=1, board unchanged, turn=1.
//  T3: moves X0,O3,X1,O4,X2 -> state=WIN, winner=01, win_line=9'b000000111;
//      a further place edge gives no pulse.
//  T4: moves X0,O1,X2,O4,X3,O5,X7,O6,X8 -> state=DRAW, winner=00;
//      cursor=9 then place -> no pulse.
//  T5: TURN_LIMIT=3, 3 sec_ticks and no place -> timeout pulse on 3rd tick,
//      turn 0->1, time_left=3.
//  T6: mid-game, new_game and place edges in the same cycle -> board=0, turn=START_PLAYER,
//      no move_ok/move_err; in PLAY, cursor=12 then place -> move_err=1.

Source files
------------

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe turn sequencer: owns the 3x3 board, validates moves, alternates players,
// runs the optional per-turn timer and resolves win/draw after every accepted move.
module ttt_game_ctrl #(
    parameter int TURN_LIMIT   = 10,
    parameter int START_PLAYER = 0,
    localparam int TW = ($clog2(TURN_LIMIT + 1) > 1) ? $clog2(TURN_LIMIT + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    cursor,
    input  logic          place,
    input  logic          new_game,
    input  logic          sec_tick,
    output logic [17:0]   board,
    output logic          turn,
    output logic [1:0]    state,
    output logic [1:0]    winner,
    output logic [8:0]    win_line,
    output logic [8:0]    sel_onehot,
    output logic          move_ok,
    output logic          move_err,
    output logic          timeout,
    output logic [TW-1:0] time_left
);

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_CHECK = 2'b01,
        ST_WIN   = 2'b10,
        ST_DRAW  = 2'b11
    } state_t;

    localparam logic [TW-1:0] LIMIT = TW'(TURN_LIMIT);
    localparam logic          START = (START_PLAYER != 0);

    // Line masks packed low-to-high: rows, columns, diagonals (lowest index has priority).
    localparam logic [71:0] LINES = {
        9'b001010100, 9'b100010001,
        9'b100100100, 9'b010010010, 9'b001001001,
        9'b111000000, 9'b000111000, 9'b000000111
    };

    state_t          r_state;
    logic [17:0]     r_board;
    logic            r_turn;
    logic [1:0]      r_winner;
    logic [8:0]      r_win_line;
    logic [8:0]      r_sel;
    logic            r_move_ok;
    logic            r_move_err;
    logic            r_timeout;
    logic [TW-1:0]   r_time;
    logic            r_place_q;
    logic            r_new_q;

    logic            w_pe;
    logic            w_ne;
    logic [1:0]      w_sym;
    logic [8:0]      w_mine;
    logic [8:0]      w_filled;
    logic [15:0]     w_filled_ext;
    logic [7:0]      w_hit;
    logic [8:0]      w_win_mask;
    logic [8:0]      w_sel_next;
    logic            w_cell_ok;

    assign w_pe         = place & ~r_place_q;
    assign w_ne         = new_game & ~r_new_q;
    assign w_sym        = r_turn ? 2'b10 : 2'b01;
    assign w_filled_ext = {7'b0, w_filled};
    assign w_cell_ok    = (cursor <= 4'd8) && !w_filled_ext[cursor];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign w_mine[gi]     = (r_board[2*gi +: 2] == w_sym);
            assign w_filled[gi]   = (r_board[2*gi +: 2] != 2'b00);
            assign w_sel_next[gi] = (cursor == 4'(gi));
        end
        for (gi = 0; gi < 8; gi++) begin : g_line
            assign w_hit[gi] = ((w_mine & LINES[9*gi +: 9]) == LINES[9*gi +: 9]);
        end
    endgenerate

    // Scan from the highest line down so the lowest-indexed complete line is kept.
    always_comb begin
        w_win_mask = 9'b0;
        for (int k = 7; k >= 0; k--) begin
            if (w_hit[k]) w_win_mask = LINES[9*k +: 9];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_PLAY;
            r_board    <= 18'b0;
            r_turn     <= START;
            r_winner   <= 2'b00;
            r_win_line <= 9'b0;
            r_sel      <= 9'b0;
            r_move_ok  <= 1'b0;
            r_move_err <= 1'b0;
            r_timeout  <= 1'b0;
            r_time     <= LIMIT;
            r_place_q  <= 1'b1;
            r_new_q    <= 1'b1;
        end else begin
            r_place_q  <= place;
            r_new_q    <= new_game;
            r_sel      <= w_sel_next;
            r_move_ok  <= 1'b0;
            r_move_err <= 1'b0;
            r_timeout  <= 1'b0;
            if (w_ne) begin
                r_state    <= ST_PLAY;
                r_board    <= 18'b0;
                r_turn     <= START;
                r_winner   <= 2'b00;
                r_win_line <= 9'b0;
                r_time     <= LIMIT;
            end else begin
                case (r_state)
                    ST_PLAY: begin
                        if (w_pe) begin
                            if (w_cell_ok) begin
                                for (int i = 0; i < 9; i++) begin
                                    if (cursor == 4'(i)) r_board[2*i +: 2] <= w_sym;
                                end
                                r_move_ok <= 1'b1;
                                r_state   <= ST_CHECK;
                            end else begin
                                r_move_err <= 1'b1;
                            end
                        end else if (sec_tick && (TURN_LIMIT > 0)) begin
                            if (r_time == TW'(1)) begin
                                r_timeout <= 1'b1;
                                r_turn    <= ~r_turn;
                                r_time    <= LIMIT;
                            end else begin
                                r_time <= r_time - TW'(1);
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (|w_hit) begin
                            r_state    <= ST_WIN;
                            r_winner   <= w_sym;
                            r_win_line <= w_win_mask;
                        end else if (&w_filled) begin
                            r_state <= ST_DRAW;
                        end else begin
                            r_state <= ST_PLAY;
                            r_turn  <= ~r_turn;
                            r_time  <= LIMIT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign board      = r_board;
    assign turn       = r_turn;
    assign state      = r_state;
    assign winner     = r_winner;
    assign win_line   = r_win_line;
    assign sel_onehot = r_sel;
    assign move_ok    = r_move_ok;
    assign move_err   = r_move_err;
    assign timeout    = r_timeout;
    assign time_left  = r_time;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed scenarios followed by random play, checked every cycle against a
// cell-array game model of the rules.
module tb_ttt_game_ctrl;
    localparam int TL = 3;
    localparam int SP = 0;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    cursor = 4'd0;
    logic          place = 1'b0;
    logic          new_game = 1'b0;
    logic          sec_tick = 1'b0;
    logic [17:0]   board;
    logic          turn;
    logic [1:0]    state;
    logic [1:0]    winner;
    logic [8:0]    win_line;
    logic [8:0]    sel_onehot;
    logic          move_ok;
    logic          move_err;
    logic          timeout;
    logic [TW-1:0] time_left;

    ttt_game_ctrl #(.TURN_LIMIT(TL), .START_PLAYER(SP)) dut (
        .clk(clk), .rst(rst), .cursor(cursor), .place(place), .new_game(new_game),
        .sec_tick(sec_tick), .board(board), .turn(turn), .state(state), .winner(winner),
        .win_line(win_line), .sel_onehot(sel_onehot), .move_ok(move_ok),
        .move_err(move_err), .timeout(timeout), .time_left(time_left)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Game model: cells hold 0 empty, 1 X, 2 O; state 0 PLAY, 1 CHECK, 2 WIN, 3 DRAW.
    int m_board [9];
    int m_turn, m_state, m_winner, m_winline, m_sel, m_time;
    int m_ok, m_err, m_to;
    bit m_pq, m_nq;
    int lines_tbl [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_new_game();
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_turn = SP; m_state = 0; m_winner = 0; m_winline = 0; m_time = TL;
    endtask

    task automatic model_step(input bit r, input int cur, input bit pl, input bit ng, input bit tk);
        bit pe, ne;
        int mover, win, full;
        m_ok = 0; m_err = 0; m_to = 0;
        if (r) begin
            model_new_game();
            m_sel = 0; m_pq = 1; m_nq = 1;
            return;
        end
        pe = pl && !m_pq;
        ne = ng && !m_nq;
        m_sel = (cur <= 8) ? (1 << cur) : 0;
        if (ne) begin
            model_new_game();
        end else if (m_state == 0) begin
            if (pe) begin
                if (cur <= 8 && m_board[cur] == 0) begin
                    m_board[cur] = m_turn + 1; m_ok = 1; m_state = 1;
                end else begin
                    m_err = 1;
                end
            end else if (tk && TL > 0) begin
                if (m_time == 1) begin
                    m_to = 1; m_turn = 1 - m_turn; m_time = TL;
                end else begin
                    m_time = m_time - 1;
                end
            end
        end else if (m_state == 1) begin
            mover = m_turn + 1;
            win = -1;
            for (int l = 0; l < 8; l++)
                if (win < 0 && m_board[lines_tbl[l][0]] == mover &&
                    m_board[lines_tbl[l][1]] == mover && m_board[lines_tbl[l][2]] == mover)
                    win = l;
            full = 1;
            for (int i = 0; i < 9; i++) if (m_board[i] == 0) full = 0;
            if (win >= 0) begin
                m_state = 2; m_winner = mover; m_winline = 0;
                for (int j = 0; j < 3; j++) m_winline += (1 << lines_tbl[win][j]);
            end else if (full == 1) begin
                m_state = 3;
            end else begin
                m_state = 0; m_turn = 1 - m_turn; m_time = TL;
            end
        end
        m_pq = pl;
        m_nq = ng;
    endtask

    task automatic check_all();
        logic [17:0] eb;
        for (int i = 0; i < 9; i++) eb[2*i +: 2] = 2'(m_board[i]);
        chk("board", 32'(board), 32'(eb));
        chk("turn", 32'(turn), 32'(m_turn));
        chk("state", 32'(state), 32'(m_state));
        chk("winner", 32'(winner), 32'(m_winner));
        chk("win_line", 32'(win_line), 32'(m_winline));
        chk("sel_onehot", 32'(sel_onehot), 32'(m_sel));
        chk("move_ok", 32'(move_ok), 32'(m_ok));
        chk("move_err", 32'(move_err), 32'(m_err));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("time_left", 32'(time_left), 32'(m_time));
    endtask

    task automatic step(input bit r, input int cur, input bit pl, input bit ng, input bit tk);
        rst = r; cursor = 4'(cur); place = pl; new_game = ng; sec_tick = tk;
        @(posedge clk);
        model_step(r, cur, pl, ng, tk);
        #1;
        check_all();
    endtask

    task automatic press(input int c);
        step(0, c, 1, 0, 0);
        step(0, c, 0, 0, 0);
    endtask

    task automatic fresh_game();
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
    endtask

    initial begin
        int seq_win[5]   = '{0, 3, 1, 4, 2};
        int seq_draw[9]  = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        int seq_dual[9]  = '{0, 3, 1, 4, 5, 6, 8, 7, 2};
        bit r, pl, ng, tk;
        int cur;

        // Place button held through reset must not act when reset releases.
        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("rst_board", 32'(board), 32'h0);
        chk("rst_time", 32'(time_left), 32'(TL));
        step(0, 0, 1, 0, 0);
        chk("held_place", 32'(move_ok), 32'h0);
        step(0, 4, 0, 0, 0);

        // T1 / T2
        step(0, 4, 1, 0, 0);
        chk("t1_cell", 32'(board[9:8]), 32'h1);
        chk("t1_ok", 32'(move_ok), 32'h1);
        step(0, 4, 0, 0, 0);
        chk("t1_state", 32'(state), 32'h0);
        chk("t1_turn", 32'(turn), 32'h1);
        step(0, 4, 1, 0, 0);
        chk("t2_err", 32'(move_err), 32'h1);
        chk("t2_board", 32'(board), 32'h100);
        step(0, 4, 0, 0, 0);

        // T3: row 0 win, then presses are ignored
        fresh_game();
        foreach (seq_win[i]) press(seq_win[i]);
        chk("t3_state", 32'(state), 32'h2);
        chk("t3_line", 32'(win_line), 32'h007);
        step(0, 5, 1, 0, 0);
        chk("t3_no_pulse", 32'({move_ok, move_err}), 32'h0);
        step(0, 5, 0, 0, 0);

        // T4: draw, then invalid cursor gives no pulse
        fresh_game();
        foreach (seq_draw[i]) press(seq_draw[i]);
        chk("t4_state", 32'(state), 32'h3);
        chk("t4_winner", 32'(winner), 32'h0);
        step(0, 9, 1, 0, 0);
        chk("t4_no_pulse", 32'({move_ok, move_err}), 32'h0);
        step(0, 9, 0, 0, 0);

        // Ninth move completes row 0 and column 2: win beats draw, row beats column
        fresh_game();
        foreach (seq_dual[i]) press(seq_dual[i]);
        chk("dual_state", 32'(state), 32'h2);
        chk("dual_line", 32'(win_line), 32'h007);

        // T5: timer expiry, then expiring tick coinciding with a move
        fresh_game();
        step(0, 0, 0, 0, 1);
        chk("t5_tl2", 32'(time_left), 32'h2);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("t5_timeout", 32'(timeout), 32'h1);
        chk("t5_turn", 32'(turn), 32'h1);
        chk("t5_reload", 32'(time_left), 32'h3);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 1);
        chk("tick_drop_ok", 32'(move_ok), 32'h1);
        chk("tick_drop_to", 32'(timeout), 32'h0);
        step(0, 0, 0, 0, 0);

        // T6: new_game beats simultaneous place; out-of-range cursor rejected
        step(0, 2, 1, 1, 0);
        chk("t6_board", 32'(board), 32'h0);
        chk("t6_pulse", 32'({move_ok, move_err}), 32'h0);
        step(0, 12, 0, 0, 0);
        step(0, 12, 1, 0, 0);
        chk("t6_err", 32'(move_err), 32'h1);
        step(0, 12, 0, 0, 0);

        // Reset during CHECK aborts the move
        step(0, 1, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("rst_check", 32'(board), 32'h0);
        step(0, 1, 0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            cur = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            pl  = $urandom_range(0, 1) == 1;
            ng  = ($urandom_range(0, 59) == 0);
            tk  = ($urandom_range(0, 3) == 0);
            step(r, cur, pl, ng, tk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
